convert_from_10: RTL and testbench
==================================

Name: convert_from_10

Overview:
Streaming decimal-to-binary converter. It is the inverse of the binary-to-decimal digit streamer.
- Accepts decimal digits most-significant first over a valid/ready handshake.
- Accumulates them by Horner's rule (acc = acc*10 + d) into a wide unsigned integer.
- Pulses done when the stream ends.
- Used to load decimal constants/results back into the wide-arithmetic datapath and as a round-trip checker for the decimal output path.

Parameters:
WIDTH, 400, width of binary accumulator/result in bits
MAX_DIGITS, 150, digit count at which the run auto-terminates
CNT_W, 8, width of digit_count; must satisfy 2^CNT_W > MAX_DIGITS

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  begin a new conversion; rising edge is the trigger, so a level held for multiple cycles starts only one run
digit  in  4  decimal digit, MSD first, legal 0..9
digit_valid  in  1  digit is presented this cycle
digit_last  in  1  qualifies digit_valid; this is the final digit
digit_ready  out  1  block accepts a digit this cycle
binary  out  WIDTH  accumulated result, unsigned
digit_count  out  CNT_W  number of legal digits accepted in the current/last run
overflow  out  1  sticky: true result exceeded 2^WIDTH-1
bad_digit  out  1  sticky: a digit >9 was presented
busy  out  1  a run is in progress (ACCUM or FINISH)
done  out  1  one-cycle pulse: result final

Behaviour:
- Reset (rst_n=0 at clk edge) takes priority over everything, including mid-run:
  - state=IDLE; binary=0, digit_count=0, overflow=0, bad_digit=0, done=0, busy=0, digit_ready=0.
  - start edge detector register cleared to 0, so a start held high across reset release counts as an edge.
- start_rise = start & ~start_q. start_q is registered every cycle.
- States: IDLE, ACCUM, FINISH.
- IDLE:
  - digit_ready=0, busy=0; binary/digit_count/flags hold the last run's values.
  - On start_rise: binary, digit_count, overflow and bad_digit clear to 0; next state is ACCUM.
- ACCUM:
  - digit_ready=1, busy=1. Accept = digit_valid & digit_ready.
  - Accept with digit<=9:
    - next = binary*10 + digit, computed at WIDTH+4 bits as (binary<<3)+(binary<<1)+digit.
    - binary <= next[WIDTH-1:0]; overflow <= overflow | (next[WIDTH+3:WIDTH]!=0).
    - digit_count <= digit_count+1.
  - Accept with digit>9: bad_digit<=1; binary and digit_count unchanged.
  - If accepted with digit_last=1, or digit_count reaches MAX_DIGITS after this accept: next state is FINISH. This holds even when the last digit is illegal.
  - Once MAX_DIGITS is reached, further digits are not accepted (digit_ready=0 in FINISH).
  - digit_valid=0: no change. An empty stream remains in ACCUM until a digit arrives.
  - start_rise in ACCUM or FINISH is ignored; no restart mid-run.
- FINISH (exactly one cycle):
  - done=1, digit_ready=0, busy=1; next state is IDLE.
  - binary, digit_count and flags are final and held until the next start_rise.
- Latency:
  - binary reflects an accepted digit on the next clock edge.
  - done is asserted in the cycle after the final digit is accepted.
  - Throughput is 1 digit/cycle.
- digit_last without digit_valid is ignored.
- start_rise in the same cycle done=1 is ignored. A new run needs a fresh rising edge once the block is in IDLE.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, ACCUM=2'd1, FINISH=2'd2)
  - DEC_MAX=4'd9
- Sub-module: mul10_add (combinational, WIDTH parameter). Takes a, d; returns a WIDTH+4-bit a*10+d.
- FSM, counter and flags stay in convert_from_10.

Test Plan:
- Basic: start pulse; digits 2,7,1,8 (last on 8) back-to-back → binary=2718, digit_count=4, done high 1 cycle, exactly 1 cycle after the 8 is accepted; overflow=0, bad_digit=0.
- Start held 2 cycles, then digits 3 and 1 (last) → a single run; binary=31; no second run begins after done while start stays high.
- Illegal digit: stream 4, 12, 2 (last) → bad_digit=1, binary=42, digit_count=2.
- Overflow: WIDTH=8; stream 2,5,6 (last) → binary=0 (256 mod 256), overflow=1. A fresh run of 2,5,5 → binary=255, overflow=0.
- Auto-terminate: MAX_DIGITS=4; stream 1,2,3,4,5 with no last flag → done after the 4th digit; binary=1234; digit 5 not accepted (digit_ready=0).
- Reset mid-run: rst_n=0 after 2 digits → all outputs 0 and state IDLE next cycle; a subsequent start with digits 9 (last) → binary=9.

Source files
------------

// File: rtl/convert_from_10_pkg.sv
// Shared constants for the decimal-to-binary streaming converter.
package convert_from_10_pkg;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCUM  = 2'd1;
   localparam logic [1:0] ST_FINISH = 2'd2;

   // Largest legal decimal digit
   localparam logic [3:0] DEC_MAX = 4'd9;

endpackage

// File: rtl/convert_from_10_mul10_add.sv
// Combinational Horner step: y = a*10 + d, widened by 4 bits so the
// carry out of the WIDTH-bit accumulator is visible to the caller.
module mul10_add #(
   parameter int WIDTH = 400
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [3:0]       i_d,
   output logic [WIDTH+3:0] o_y
);

   logic [WIDTH+3:0] w_a_ext;

   // a*10 is built as a*8 + a*2 so no multiplier is inferred
   assign w_a_ext = {4'b0000, i_a};
   assign o_y     = (w_a_ext << 3) + (w_a_ext << 1) + {{WIDTH{1'b0}}, i_d};

endmodule

// File: rtl/convert_from_10.sv
// Streaming decimal-to-binary converter. Digits arrive MSD first over a
// valid/ready handshake and are folded into a wide accumulator by Horner's
// rule; a one-cycle done pulse marks the final result.
module convert_from_10
   import convert_from_10_pkg::*;
#(
   parameter int WIDTH      = 400,
   parameter int MAX_DIGITS = 150,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       digit,
   input  logic             digit_valid,
   input  logic             digit_last,
   output logic             digit_ready,
   output logic [WIDTH-1:0] binary,
   output logic [CNT_W-1:0] digit_count,
   output logic             overflow,
   output logic             bad_digit,
   output logic             busy,
   output logic             done
);

   logic [1:0]       r_state;
   logic             r_start_q;
   logic [WIDTH-1:0] r_binary;
   logic [CNT_W-1:0] r_count;
   logic             r_ovf;
   logic             r_bad;

   logic             w_start_rise;
   logic             w_accept;
   logic             w_legal;
   logic [WIDTH+3:0] w_next;
   logic [CNT_W-1:0] w_count_inc;
   logic             w_hit_max;
   logic             w_end;

   mul10_add #(.WIDTH(WIDTH)) u_mul10_add (
      .i_a (r_binary),
      .i_d (digit),
      .o_y (w_next)
   );

   assign w_start_rise = start & ~r_start_q;
   assign w_accept     = digit_valid & (r_state == ST_ACCUM);
   assign w_legal      = (digit <= DEC_MAX);
   assign w_count_inc  = r_count + 1'b1;
   // An illegal digit never bumps the count, so only a legal accept can
   // land on the digit limit.
   assign w_hit_max    = w_legal & (w_count_inc == CNT_W'(MAX_DIGITS));
   assign w_end        = w_accept & (digit_last | w_hit_max);

   assign digit_ready  = (r_state == ST_ACCUM);
   assign busy         = (r_state != ST_IDLE);
   assign done         = (r_state == ST_FINISH);
   assign binary       = r_binary;
   assign digit_count  = r_count;
   assign overflow     = r_ovf;
   assign bad_digit    = r_bad;

   // Start edge detector; cleared in reset so a start held through reset
   // release still counts as a fresh edge.
   always_ff @(posedge clk) begin
      if (!rst_n) r_start_q <= 1'b0;
      else        r_start_q <= start;
   end

   // Run FSM with accumulator, digit counter and sticky flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_binary <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
         r_bad    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_start_rise) begin
                  r_binary <= '0;
                  r_count  <= '0;
                  r_ovf    <= 1'b0;
                  r_bad    <= 1'b0;
                  r_state  <= ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               if (w_accept) begin
                  if (w_legal) begin
                     r_binary <= w_next[WIDTH-1:0];
                     r_ovf    <= r_ovf | (w_next[WIDTH+3:WIDTH] != 4'd0);
                     r_count  <= w_count_inc;
                  end else begin
                     r_bad    <= 1'b1;
                  end
               end
               if (w_end) r_state <= ST_FINISH;
            end
            ST_FINISH: r_state <= ST_IDLE;
            default:   r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_convert_from_10.sv
// Randomized scoreboard bench for convert_from_10 with small parameters so
// overflow and the digit limit are reachable in short streams.
module tb_convert_from_10;

   localparam int TW = 16;
   localparam int TM = 6;
   localparam int TC = 3;

   typedef struct {
      logic [TW-1:0] bin;
      logic [TC-1:0] cnt;
      logic          ovf;
      logic          bad;
      int            cyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [3:0]    digit;
   logic          digit_valid;
   logic          digit_last;
   logic          digit_ready;
   logic [TW-1:0] binary;
   logic [TC-1:0] digit_count;
   logic          overflow;
   logic          bad_digit;
   logic          busy;
   logic          done;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   exp_t sb[$];
   logic [3:0] stim[$];

   convert_from_10 #(.WIDTH(TW), .MAX_DIGITS(TM), .CNT_W(TC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .digit       (digit),
      .digit_valid (digit_valid),
      .digit_last  (digit_last),
      .digit_ready (digit_ready),
      .binary      (binary),
      .digit_count (digit_count),
      .overflow    (overflow),
      .bad_digit   (bad_digit),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest expected result.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && done === 1'b1) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: got done with empty scoreboard (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("done_cycle",  cyc,         e.cyc);
            chk("binary",      binary,      e.bin);
            chk("digit_count", digit_count, e.cnt);
            chk("overflow",    overflow,    e.ovf);
            chk("bad_digit",   bad_digit,   e.bad);
         end
      end
   end

   // Drive one run from stim[]; last_idx marks the digit carrying
   // digit_last (-1 for none). The reference keeps the exact decimal value
   // and derives the truncated result and overflow from it.
   task automatic run_stream(input int hold, input int last_idx, input bit gaps);
      logic [63:0] exact = 0;
      int cnt = 0, i = 0, hcnt = 1, to = 0;
      bit bad = 0, fin = 0;
      exp_t e;
      @(negedge clk);
      start = 1'b1; digit_valid = 1'b0; digit_last = 1'b0;
      while (!fin && to < 200) begin
         @(negedge clk);
         to++;
         chk("step_binary", binary, exact[TW-1:0]);
         chk("step_count",  digit_count, cnt);
         if (hcnt >= hold) start = 1'b0;
         else hcnt++;
         if (gaps && $urandom_range(0, 3) == 0) begin
            digit_valid = 1'b0;
            digit_last  = 1'($urandom_range(0, 1));
            digit       = 4'($urandom);
         end else if (i < stim.size()) begin
            digit       = stim[i];
            digit_valid = 1'b1;
            digit_last  = (i == last_idx);
            if (digit_ready) begin
               if (digit <= 4'd9) begin
                  exact = exact * 10 + 64'(digit);
                  cnt++;
               end else begin
                  bad = 1'b1;
               end
               if (digit_last || cnt == TM) begin
                  fin   = 1'b1;
                  e.bin = exact[TW-1:0];
                  e.cnt = TC'(cnt);
                  e.ovf = ((exact >> TW) != 0);
                  e.bad = bad;
                  e.cyc = cyc + 1;
                  sb.push_back(e);
               end
               i++;
            end
         end else begin
            digit_valid = 1'b0;
         end
      end
      if (!fin) begin
         n_tests++;
         n_fail++;
         $display("FAIL run_timeout: got no end of run, expected one within 200 cycles");
      end
      @(negedge clk);
      chk("ready_in_finish", digit_ready, 1'b0);
      chk("busy_in_finish",  busy,        1'b1);
      digit_valid = 1'b0; digit_last = 1'b0;
      @(negedge clk);
      chk("idle_busy",   busy,        1'b0);
      chk("idle_ready",  digit_ready, 1'b0);
      chk("idle_binary", binary,      exact[TW-1:0]);
      chk("idle_count",  digit_count, cnt);
      @(negedge clk);
      chk("no_retrigger", busy, 1'b0);
      start = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got simulation still running, expected finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; digit = 4'd0; digit_valid = 1'b0; digit_last = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_binary", binary,      0);
      chk("rst_count",  digit_count, 0);
      chk("rst_ovf",    overflow,    0);
      chk("rst_bad",    bad_digit,   0);
      chk("rst_busy",   busy,        0);
      chk("rst_ready",  digit_ready, 0);
      chk("rst_done",   done,        0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed streams
      stim = '{4'd2, 4'd7, 4'd1, 4'd8};       run_stream(1, 3, 1'b0);
      stim = '{4'd3, 4'd1};                   run_stream(9, 1, 1'b0);
      stim = '{4'd4, 4'd12, 4'd2};            run_stream(1, 2, 1'b0);
      stim = '{4'd6, 4'd5, 4'd5, 4'd3, 4'd6}; run_stream(1, 4, 1'b0);
      stim = '{4'd6, 4'd5, 4'd5, 4'd3, 4'd5}; run_stream(1, 4, 1'b0);
      stim = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7}; run_stream(2, -1, 1'b0);
      stim = '{4'd7, 4'd15};                  run_stream(1, 1, 1'b1);

      // Reset in the middle of a run, start held across release
      @(negedge clk); start = 1'b1;
      @(negedge clk); digit = 4'd5; digit_valid = 1'b1; digit_last = 1'b0;
      @(negedge clk); digit = 4'd3;
      @(negedge clk); digit_valid = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_binary", binary,      0);
      chk("midrst_count",  digit_count, 0);
      chk("midrst_busy",   busy,        0);
      chk("midrst_ready",  digit_ready, 0);
      chk("midrst_done",   done,        0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("postrst_busy", busy, 1'b1);
      begin
         exp_t e;
         e.bin = 16'd9; e.cnt = 3'd1; e.ovf = 1'b0; e.bad = 1'b0; e.cyc = cyc + 1;
         sb.push_back(e);
      end
      digit = 4'd9; digit_valid = 1'b1; digit_last = 1'b1;
      @(negedge clk); digit_valid = 1'b0; digit_last = 1'b0;
      @(negedge clk); start = 1'b0;
      @(negedge clk);

      // Randomized streams
      for (int r = 0; r < 40; r++) begin
         int n;
         n = $urandom_range(1, 8);
         stim.delete();
         for (int k = 0; k < n; k++)
            stim.push_back(($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                       : 4'($urandom_range(0, 9)));
         run_stream($urandom_range(1, 12), n - 1, 1'b1);
      end

      repeat (3) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
